// File: rtl/regfile_wb_arbiter_if.sv
// Bundle of the two write requesters, the reservation path and the
// register-file write port shared by regfile_wb_arbiter.
interface regfile_wb_arbiter_if #(
    parameter int NUM_REGS = 15
);
    logic                a_valid;
    logic [3:0]          a_dest;
    logic [31:0]         a_data;
    logic                a_ready;

    logic                b_valid;
    logic [3:0]          b_dest;
    logic [31:0]         b_data;
    logic                b_ready;

    logic                b_reserve;
    logic [3:0]          b_reserve_dest;

    logic                writeBackEn;
    logic [3:0]          Dest_wb;
    logic [31:0]         Result_WB;
    logic [NUM_REGS-1:0] pending;
    logic                bad_dest;

    // Requester side: pipeline WB stage, multi-cycle unit and hazard unit.
    modport master (
        output a_valid, a_dest, a_data,
        output b_valid, b_dest, b_data,
        output b_reserve, b_reserve_dest,
        input  a_ready, b_ready,
        input  writeBackEn, Dest_wb, Result_WB, pending, bad_dest
    );

    // Arbiter side.
    modport slave (
        input  a_valid, a_dest, a_data,
        input  b_valid, b_dest, b_data,
        input  b_reserve, b_reserve_dest,
        output a_ready, b_ready,
        output writeBackEn, Dest_wb, Result_WB, pending, bad_dest
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between the in-order WB stage (A)
// and a multi-cycle unit (B), with starvation relief for B and a pending-write scoreboard.
module regfile_wb_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int NUM_REGS = 15
) (
    input  logic               clk,
    input  logic               reset,
    regfile_wb_arbiter_if.slave bus
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [3:0] PC_IDX     = 4'd15;

    logic                force_b;
    logic                grant_a;
    logic                grant_b;

    logic [3:0]          wait_q,    wait_d;
    logic                we_q,      we_d;
    logic [3:0]          dest_q,    dest_d;
    logic [31:0]         data_q,    data_d;
    logic                bad_q,     bad_d;
    logic [NUM_REGS-1:0] pending_q, pending_d;

    // A wins unless B has been blocked for MAX_WAIT consecutive cycles.
    always_comb begin
        force_b = (wait_q == MAX_WAIT_C) && bus.b_valid;
        grant_b = force_b || (bus.b_valid && !bus.a_valid);
        grant_a = bus.a_valid && !force_b;
    end

    assign bus.a_ready = grant_a;
    assign bus.b_ready = grant_b;

    always_comb begin
        wait_d = 4'd0;
        if (bus.b_valid && !grant_b) begin
            wait_d = (wait_q == MAX_WAIT_C) ? MAX_WAIT_C : wait_q + 4'd1;
        end
    end

    // A grant to PC is accepted but not written; the address/data regs keep their old value.
    always_comb begin
        we_d   = 1'b0;
        dest_d = dest_q;
        data_d = data_q;
        if (grant_a && (bus.a_dest != PC_IDX)) begin
            we_d   = 1'b1;
            dest_d = bus.a_dest;
            data_d = bus.a_data;
        end else if (grant_b && (bus.b_dest != PC_IDX)) begin
            we_d   = 1'b1;
            dest_d = bus.b_dest;
            data_d = bus.b_data;
        end
    end

    always_comb begin
        bad_d = bad_q
              | (grant_a && (bus.a_dest == PC_IDX))
              | (grant_b && (bus.b_dest == PC_IDX))
              | (bus.b_reserve && (bus.b_reserve_dest == PC_IDX));
    end

    // Per-register scoreboard bit; a new reservation beats a same-cycle retiring write.
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pending
            logic set_bit;
            logic clr_bit;
            assign set_bit = bus.b_reserve && (bus.b_reserve_dest == 4'(gi));
            assign clr_bit = grant_b && (bus.b_dest == 4'(gi));
            assign pending_d[gi] = set_bit ? 1'b1 : (clr_bit ? 1'b0 : pending_q[gi]);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_q    <= 4'd0;
            we_q      <= 1'b0;
            dest_q    <= 4'd0;
            data_q    <= 32'd0;
            bad_q     <= 1'b0;
            pending_q <= '0;
        end else begin
            wait_q    <= wait_d;
            we_q      <= we_d;
            dest_q    <= dest_d;
            data_q    <= data_d;
            bad_q     <= bad_d;
            pending_q <= pending_d;
        end
    end

    assign bus.writeBackEn = we_q;
    assign bus.Dest_wb     = dest_q;
    assign bus.Result_WB   = data_q;
    assign bus.pending     = pending_q;
    assign bus.bad_dest    = bad_q;

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (Dest_wb / Result_WB / writeBackEn) between two requesters.
- Requester A is the in-order pipeline WB stage. Requester B is a multi-cycle unit (multiplier / load miss path).
- Fixed priority to A, with a starvation counter that forces a B grant after MAX_WAIT cycles.
- Keeps a pending-write scoreboard of B's outstanding destinations, which hazard detection uses to stall readers.

Parameters:
- MAX_WAIT, 4: consecutive cycles B may be valid-and-blocked before a forced B grant (1..15).
- NUM_REGS, 15: architectural registers held in the register file (indices 0..14).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- a_valid  in  1  pipeline WB write request.
- a_dest  in  4  A destination register.
- a_data  in  32  A write data.
- a_ready  out  1  A accepted this cycle (combinational).
- b_valid  in  1  multi-cycle unit write request.
- b_dest  in  4  B destination register.
- b_data  in  32  B write data.
- b_ready  out  1  B accepted this cycle (combinational).
- b_reserve  in  1  B issued an op; marks b_reserve_dest pending.
- b_reserve_dest  in  4  register to reserve.
- writeBackEn  out  1  register-file write enable (registered).
- Dest_wb  out  4  register-file write address (registered).
- Result_WB  out  32  register-file write data (registered).
- pending  out  15  bit i = 1: register i has an outstanding B write.
- bad_dest  out  1  sticky flag: a request or reservation targeted index 15.

Behaviour:
- Reset (reset == 0, asynchronous): writeBackEn=0, Dest_wb=0, Result_WB=0, pending=0, wait counter=0, bad_dest=0. Outputs hold these values while reset is low. Reset mid-transfer discards any staged write.
- Grant, combinational on current inputs:
  - force = (wait_cnt == MAX_WAIT) && b_valid.
  - If force: grant B.
  - Else if a_valid: grant A.
  - Else if b_valid: grant B.
  - a_ready = grant A; b_ready = grant B. Exactly one requester is granted per cycle, at most.
- Output register, 1-cycle latency:
  - On the rising edge after a grant: writeBackEn=1, and Dest_wb/Result_WB take the granted dest/data.
  - With no grant: writeBackEn=0, and Dest_wb/Result_WB hold their previous values.
  - The register file samples on the following falling edge.
- Wait counter:
  - b_valid && !b_ready: increments, saturating at MAX_WAIT.
  - b_ready, or b_valid low: clears to 0.
  - A forced B grant blocks A for exactly that one cycle. A keeps a_valid asserted and is granted next cycle.
- Scoreboard:
  - b_reserve with dest < 15 sets pending[dest].
  - B grant with b_dest < 15 clears pending[b_dest].
  - Same-cycle set and clear of the same bit: set wins (new reservation outstanding).
  - Set of an already-set bit: no change.
  - Clear of an unset bit: no change.
  - A grants never touch pending.
- Index 15 (PC, not stored in the register file):
  - A granted request with dest 15 is accepted (ready=1), but writeBackEn stays 0 for it. It still consumes the grant slot.
  - Same for B.
  - A reservation of 15 is ignored.
  - Any of these sets bad_dest, which clears only on reset.
- Ordering: the upstream hazard unit must stall A on a pending register. The arbiter does not reorder or merge same-destination writes.

Test Plan:
- Reset release, no requests -> writeBackEn=0, pending=15'h0, a_ready=b_ready=0.
- a_valid=1, a_dest=3, a_data=32'hDEAD_BEEF -> a_ready=1 same cycle; next cycle writeBackEn=1, Dest_wb=3, Result_WB=32'hDEAD_BEEF; following cycle writeBackEn=0.
- A and B valid continuously, MAX_WAIT=4 -> A granted 4 cycles, B granted on the 5th (a_ready=0, b_ready=1), then A resumes; wait_cnt back to 0.
- b_reserve dest 7, then later B write to 7 -> pending[7]=1 until the cycle after the B grant. Then a same-cycle b_reserve of 7 with a B grant to 7 -> pending[7] stays 1.
- a_valid with a_dest=15 -> a_ready=1, writeBackEn stays 0, bad_dest=1 and sticky; b_reserve of 15 leaves pending unchanged.
- reset driven low asynchronously one cycle after a grant, mid-clock -> writeBackEn, pending and wait_cnt go to 0 immediately, with no write issued after release.
